// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog timeout sequencer.
// The state encodings double as the debug/readback value on the state port.
// The default key and reset pulse width are the reset-request defaults for wdt_ctrl.
package wdt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_WARN  = 2'b11,
    ST_RESET = 2'b10
  } wdt_state_e;

  localparam logic [7:0] WDT_KEY       = 8'hA5;
  localparam int         WDT_RST_PULSE = 16;

endpackage

// File: rtl/wdt_prescaler.sv
// Prescaler: ticks once every 2^presc pclk cycles while run is high.
// Latency: tick is combinational from the divider register (no added delay).
// Backpressure: none; clr or !run returns the divider to zero.
module wdt_prescaler
  import wdt_pkg::*;
#(
  parameter int PRESC_W = 4
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               run,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  // Wide enough to count up to 2^(2^PRESC_W - 1) - 1 for the largest presc.
  localparam int DIV_W = (1 << PRESC_W) - 1;

  logic [DIV_W-1:0] div_q, div_d, limit;

  // Terminal count 2^presc - 1: the low presc bits set, the rest clear.
  always_comb begin
    limit = '0;
    for (int i = 0; i < DIV_W; i++) begin
      limit[i] = (i < int'(presc));
    end
  end

  assign tick = run && (div_q == limit);

  // Divider advance: wrap on tick, hold at zero when stopped or cleared.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (!run || clr || tick) div_d = '0;
  end

  // Divider register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) div_q <= '0;
    else      div_q <= div_d;
  end

endmodule

// File: rtl/wdt_ctrl.sv
// Watchdog timeout sequencer: prescaled down-counter with keyed kick, warn irq, reset pulse.
// Latency: all outputs registered; a kick reloads cnt on the next edge.
// Backpressure: none; kicks and enable changes are ignored while the reset pulse runs.
// Optional: define WDT_BADKEY_RST_EN to turn a wrong-key kick into an immediate violation reset.
module wdt_ctrl
  import wdt_pkg::*;
#(
  parameter int         CNT_W     = 32,
  parameter int         PRESC_W   = 4,
  parameter int         RST_PULSE = WDT_RST_PULSE,
  parameter logic [7:0] KEY       = WDT_KEY
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               wdt_en,
  input  logic               kick,
  input  logic [7:0]         kick_key,
  input  logic [CNT_W-1:0]   timeout,
  input  logic [CNT_W-1:0]   warn_thresh,
  input  logic [PRESC_W-1:0] presc,
  input  logic               flag_clr,
  output logic [CNT_W-1:0]   cnt,
  output logic               wdt_irq,
  output logic               wdt_rst_n,
  output logic               expired,
  output logic [1:0]         state
);

  localparam int PC_W = $clog2(RST_PULSE + 1);

  wdt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             irq_q, irq_d;
  logic             rst_n_q, rst_n_d;
  logic             expired_q, expired_d;
  logic             active, kick_ok, tick, enter_rst;

  assign active  = (state_q == ST_RUN) || (state_q == ST_WARN);
  assign kick_ok = kick && (kick_key == KEY);
  // Saturating decrement: an already-zero count stays zero and still expires.
  assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);

`ifdef WDT_BADKEY_RST_EN
  logic kick_bad;
  assign kick_bad = kick && (kick_key != KEY);
`endif

  wdt_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .pclk  (pclk),
    .rst   (rst),
    .run   (active),
    .clr   (kick_ok),
    .presc (presc),
    .tick  (tick)
  );

  // Next-state, count reload/decrement and reset-pulse timing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (wdt_en) begin
          state_d = ST_RUN;
          cnt_d   = timeout;
        end
      end
      ST_RUN, ST_WARN: begin
        if (!wdt_en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (kick_ok) begin
          // A kick beats a coincident tick: reload, no decrement.
          state_d = ST_RUN;
          cnt_d   = timeout;
`ifdef WDT_BADKEY_RST_EN
        end else if (kick_bad) begin
          state_d = ST_RESET;
`endif
        end else if (tick) begin
          cnt_d = cnt_dec;
          if (cnt_dec == '0)
            state_d = ST_RESET;
          else if ((state_q == ST_RUN) && (cnt_dec <= warn_thresh))
            state_d = ST_WARN;
        end
      end
      ST_RESET: begin
        if (pc_q == PC_W'(1)) begin
          state_d = wdt_en ? ST_RUN : ST_IDLE;
          cnt_d   = wdt_en ? timeout : '0;
        end else begin
          pc_d = pc_q - PC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    enter_rst = (state_d == ST_RESET) && (state_q != ST_RESET);
    if (enter_rst) pc_d = PC_W'(RST_PULSE);

    // Outputs follow the next state so they change on the transition edge.
    irq_d     = (state_d == ST_WARN);
    rst_n_d   = (state_d != ST_RESET);
    // Setting on expiry beats a simultaneous clear.
    expired_d = enter_rst ? 1'b1 : (flag_clr ? 1'b0 : expired_q);
  end

  // State and output registers.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pc_q      <= '0;
      irq_q     <= 1'b0;
      rst_n_q   <= 1'b1;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      irq_q     <= irq_d;
      rst_n_q   <= rst_n_d;
      expired_q <= expired_d;
    end
  end

  assign cnt       = cnt_q;
  assign wdt_irq   = irq_q;
  assign wdt_rst_n = rst_n_q;
  assign expired   = expired_q;
  assign state     = state_q;

endmodule

// File: tb/tb_wdt_ctrl.sv
// Directed bench for wdt_ctrl with an expectation queue drained after every clock.
module tb_wdt_ctrl;

  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, WARN = 2'b11, RST = 2'b10;
  localparam int S_CNT = 0, S_ST = 1, S_IRQ = 2, S_RSTN = 3, S_EXP = 4;

  logic        pclk = 1'b0;
  logic        rst, wdt_en, kick, flag_clr;
  logic [7:0]  kick_key;
  logic [31:0] timeout, warn_thresh;
  logic [3:0]  presc;
  logic [31:0] cnt;
  logic        wdt_irq, wdt_rst_n, expired;
  logic [1:0]  state;

  wdt_ctrl dut (
    .pclk        (pclk),
    .rst         (rst),
    .wdt_en      (wdt_en),
    .kick        (kick),
    .kick_key    (kick_key),
    .timeout     (timeout),
    .warn_thresh (warn_thresh),
    .presc       (presc),
    .flag_clr    (flag_clr),
    .cnt         (cnt),
    .wdt_irq     (wdt_irq),
    .wdt_rst_n   (wdt_rst_n),
    .expired     (expired),
    .state       (state)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int          sig;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] obs(input int sig);
    case (sig)
      S_CNT:   return cnt;
      S_ST:    return {30'd0, state};
      S_IRQ:   return {31'd0, wdt_irq};
      S_RSTN:  return {31'd0, wdt_rst_n};
      default: return {31'd0, expired};
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] v);
    exp_t e;
    e.sig = sig;
    e.val = v;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic exp_all(input string tag, input logic [1:0] st, input logic [31:0] c,
                         input logic irq, input logic rn, input logic ex);
    push({tag, "/state"}, S_ST, {30'd0, st});
    push({tag, "/cnt"}, S_CNT, c);
    push({tag, "/irq"}, S_IRQ, {31'd0, irq});
    push({tag, "/rst_n"}, S_RSTN, {31'd0, rn});
    push({tag, "/expired"}, S_EXP, {31'd0, ex});
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.sig);
      n_cmp++;
      assert (o === e.val)
      else begin
        n_bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
    drain();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; wdt_en = 1'b0; kick = 1'b0; kick_key = 8'h00; flag_clr = 1'b0;
    timeout = 32'd0; warn_thresh = 32'd0; presc = 4'd0;
    repeat (2) @(posedge pclk);
    #1;
    exp_all("reset", IDLE, 0, 0, 1, 0);
    drain();
    rst = 1'b1;

    // Kick in IDLE is ignored.
    kick = 1'b1; kick_key = 8'hA5;
    push("idle_kick", S_ST, IDLE);
    step();
    kick = 1'b0;

    // Basic countdown to expiry with presc=0.
    timeout = 32'd5; warn_thresh = 32'd2; wdt_en = 1'b1;
    exp_all("enable", RUN, 5, 0, 1, 0); step();
    push("cnt4", S_CNT, 4); push("run4", S_ST, RUN); step();
    push("cnt3", S_CNT, 3); push("run3", S_ST, RUN); step();
    exp_all("warn", WARN, 2, 1, 1, 0); step();
    push("cnt1", S_CNT, 1); push("warn1", S_ST, WARN); step();
    exp_all("expire", RST, 0, 0, 0, 1); step();
    for (int i = 1; i < 16; i++) begin
      kick = (i == 5);
      push("pulse_low", S_RSTN, 0);
      push("pulse_state", S_ST, RST);
      step();
    end
    kick = 1'b0;
    exp_all("pulse_end_run", RUN, 5, 0, 1, 1); step();

    // Flag clear, then periodic kicking keeps the watchdog alive.
    flag_clr = 1'b1;
    push("flag_clr", S_EXP, 0); push("clr_cnt4", S_CNT, 4); step();
    flag_clr = 1'b0;
    push("cnt3b", S_CNT, 3); step();
    exp_all("warn_b", WARN, 2, 1, 1, 0); step();
    kick = 1'b1; kick_key = 8'hA5;
    exp_all("kick_in_warn", RUN, 5, 0, 1, 0); step();
    kick = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push("alive4", S_CNT, 4); step();
      push("alive3", S_CNT, 3); step();
      kick = 1'b1;
      push("alive_kick", S_CNT, 5); push("alive_rstn", S_RSTN, 1);
      push("alive_state", S_ST, RUN);
      step();
      kick = 1'b0;
    end

    // Wrong-key kick at cnt=4.
    push("pre_bad4", S_CNT, 4); step();
    kick = 1'b1; kick_key = 8'h3C;
`ifdef WDT_BADKEY_RST_EN
    push("badkey_state", S_ST, RST); push("badkey_rstn", S_RSTN, 0);
    push("badkey_exp", S_EXP, 1);
`else
    push("badkey_cnt", S_CNT, 3); push("badkey_state", S_ST, RUN);
    push("badkey_exp", S_EXP, 0);
`endif
    step();
    kick = 1'b0;
    rst = 1'b0;
    #1;
    exp_all("rst_async", IDLE, 0, 0, 1, 0);
    drain();
    @(posedge pclk);
    #1;
    rst = 1'b1;

    // Enable dropped in WARN.
    exp_all("reen", RUN, 5, 0, 1, 0); step();
    push("d4", S_CNT, 4); step();
    push("d3", S_CNT, 3); step();
    exp_all("d_warn", WARN, 2, 1, 1, 0); step();
    wdt_en = 1'b0;
    exp_all("en_drop_warn", IDLE, 0, 0, 1, 0); step();

    // Clear coincident with expiry, then enable dropped mid-pulse.
    wdt_en = 1'b1;
    push("e5", S_CNT, 5); step();
    push("e4", S_CNT, 4); step();
    push("e3", S_CNT, 3); step();
    push("e2", S_CNT, 2); step();
    push("e1", S_CNT, 1); step();
    flag_clr = 1'b1;
    exp_all("clr_vs_set", RST, 0, 0, 0, 1); step();
    flag_clr = 1'b0;
    for (int i = 1; i < 16; i++) begin
      if (i == 3) wdt_en = 1'b0;
      push("pulse2_low", S_RSTN, 0);
      step();
    end
    exp_all("pulse_end_idle", IDLE, 0, 0, 1, 1); step();

    // presc=3: decrement every 8 cycles, expiry 16 cycles after enable.
    presc = 4'd3; timeout = 32'd2; warn_thresh = 32'd0; wdt_en = 1'b1;
    push("p_en", S_CNT, 2); push("p_en_st", S_ST, RUN); step();
    for (int i = 1; i < 16; i++) begin
      push("p_cnt", S_CNT, (i < 8) ? 32'd2 : 32'd1);
      push("p_st", S_ST, RUN);
      step();
    end
    push("p_exp_st", S_ST, RST); push("p_exp_cnt", S_CNT, 0);
    push("p_exp_rstn", S_RSTN, 0); step();
    for (int i = 0; i < 4; i++) begin
      push("p_pulse", S_RSTN, 0); step();
    end
    rst = 1'b0;
    #1;
    exp_all("rst_mid_pulse", IDLE, 0, 0, 1, 0);
    drain();
    @(posedge pclk);
    #1;
    rst = 1'b1;

    // timeout=0: the first tick expires.
    presc = 4'd0; timeout = 32'd0;
    push("z_en_st", S_ST, RUN); push("z_en_cnt", S_CNT, 0); step();
    exp_all("z_expire", RST, 0, 0, 0, 1); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
